// File: rtl/nco_phase_gen.sv
// Phase-accumulator NCO front end: produces the phase word for a CORDIC rotator.
// FTW/POW reload through a one-deep valid/ready slot, applied only on an ena edge.
module nco_phase_gen #(
    parameter int ACC_WIDTH = 32,
    parameter int PHA_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 ena,
    input  logic                 phase_clr,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic                 cfg_sel,
    input  logic [ACC_WIDTH-1:0] cfg_data,
    output logic [PHA_WIDTH-1:0] phase_out,
    output logic                 phase_vld,
    output logic                 wrap_o
);

    typedef enum logic {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } cfg_state_t;

    cfg_state_t           state;
    logic                 pend_sel;
    logic [ACC_WIDTH-1:0] pend_data;
    logic [ACC_WIDTH-1:0] ftw_act;
    logic [PHA_WIDTH-1:0] pow_act;

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [PHA_WIDTH-1:0] ph_s1;
    logic                 v1;
    logic                 cy;
    logic                 w1;

    // Extra top bit of the sum is the accumulator carry-out.
    assign acc_sum   = {1'b0, acc} + {1'b0, ftw_act};
    assign cfg_ready = (state == EMPTY);

    // Config slot: accept while EMPTY, apply on the next ena edge. Accept and
    // apply can never share an edge because they live in different states.
    // NOTE: all state is updated with non-blocking assignments so every block
    // sees pre-edge values, which is what lets a config applied on an edge
    // leave that edge's accumulator step untouched.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            pend_sel  <= 1'b0;
            pend_data <= '0;
            ftw_act   <= '0;
            pow_act   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (cfg_valid) begin
                        pend_sel  <= cfg_sel;
                        pend_data <= cfg_data;
                        state     <= PENDING;
                    end
                end
                PENDING: begin
                    if (ena) begin
                        if (pend_sel) pow_act <= pend_data[PHA_WIDTH-1:0];
                        else          ftw_act <= pend_data;
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Stage 1: sample the accumulator top bits and advance by one step.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            ph_s1 <= '0;
            v1    <= 1'b0;
            cy    <= 1'b0;
            w1    <= 1'b0;
        end else if (ena) begin
            ph_s1 <= acc[ACC_WIDTH-1 -: PHA_WIDTH] + pow_act;
            acc   <= phase_clr ? '0 : acc_sum[ACC_WIDTH-1:0];
            cy    <= ~phase_clr & acc_sum[ACC_WIDTH];
            w1    <= cy;
            v1    <= 1'b1;
        end else begin
            v1 <= 1'b0;
        end
    end

    // Stage 2: registered outputs; the phase word holds between samples.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            phase_out <= '0;
            phase_vld <= 1'b0;
            wrap_o    <= 1'b0;
        end else begin
            phase_vld <= v1;
            wrap_o    <= v1 & w1;
            if (v1) phase_out <= ph_s1;
        end
    end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Self-checking bench for nco_phase_gen: vector table, directed corner cases,
// and randomized traffic against an arithmetic reference model.
module tb_nco_phase_gen;

    localparam int ACC_WIDTH = 32;
    localparam int PHA_WIDTH = 16;
    localparam longint unsigned ACC_MOD = 64'h1_0000_0000;
    localparam longint unsigned PHA_MOD = 64'h1_0000;

    logic                 clk_in = 1'b0;
    logic                 reset  = 1'b1;
    logic                 ena = 1'b0;
    logic                 phase_clr = 1'b0;
    logic                 cfg_valid = 1'b0;
    logic                 cfg_sel = 1'b0;
    logic [ACC_WIDTH-1:0] cfg_data = '0;
    logic                 cfg_ready;
    logic [PHA_WIDTH-1:0] phase_out;
    logic                 phase_vld;
    logic                 wrap_o;

    int n_cmp = 0;
    int n_bad = 0;

    nco_phase_gen #(.ACC_WIDTH(ACC_WIDTH), .PHA_WIDTH(PHA_WIDTH)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .ena       (ena),
        .phase_clr (phase_clr),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .phase_out (phase_out),
        .phase_vld (phase_vld),
        .wrap_o    (wrap_o)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Reference model: the accumulator as a plain integer, the pending config
    // as a flag plus value, and the last sample waiting to be shown.
    longint unsigned m_acc, m_ftw, m_pow, m_pend_data, s1_ph, m_out;
    bit              m_pend, m_pend_sel, m_carry, s1_v, s1_w, m_vld, m_wrap;

    task automatic model_reset();
        m_acc = 0; m_ftw = 0; m_pow = 0; m_pend_data = 0;
        m_pend = 0; m_pend_sel = 0; m_carry = 0;
        s1_v = 0; s1_w = 0; s1_ph = 0;
        m_out = 0; m_vld = 0; m_wrap = 0;
    endtask

    task automatic model_edge(input bit e, input bit c, input bit v, input bit s,
                              input logic [31:0] d);
        bit              pend_was;
        longint unsigned sum;
        pend_was = m_pend;
        m_vld  = s1_v;
        m_wrap = s1_v && s1_w;
        if (s1_v) m_out = s1_ph;
        if (e) begin
            s1_ph   = ((m_acc >> (ACC_WIDTH - PHA_WIDTH)) + m_pow) % PHA_MOD;
            s1_w    = m_carry;
            s1_v    = 1'b1;
            sum     = m_acc + m_ftw;
            m_carry = !c && (sum >= ACC_MOD);
            m_acc   = c ? 0 : sum % ACC_MOD;
            if (pend_was) begin
                if (m_pend_sel) m_pow = m_pend_data % PHA_MOD;
                else            m_ftw = m_pend_data;
                m_pend = 1'b0;
            end
        end else begin
            s1_v = 1'b0;
        end
        if (!pend_was && v) begin
            m_pend      = 1'b1;
            m_pend_sel  = s;
            m_pend_data = 64'(d);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge, then compare at the next falling edge.
    task automatic step(input bit e, input bit c, input bit v, input bit s,
                        input logic [31:0] d);
        ena = e; phase_clr = c; cfg_valid = v; cfg_sel = s; cfg_data = d;
        @(posedge clk_in);
        model_edge(e, c, v, s, d);
        @(negedge clk_in);
        check("model phase_out", 32'(phase_out), 32'(m_out));
        check("model phase_vld", 32'(phase_vld), 32'(m_vld));
        check("model wrap_o",    32'(wrap_o),    32'(m_wrap));
        check("model cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    endtask

    task automatic do_reset();
        ena = 0; phase_clr = 0; cfg_valid = 0; cfg_sel = 0; cfg_data = '0;
        reset = 1'b1;
        #1;
        check("reset phase_out", 32'(phase_out), 32'h0);
        check("reset phase_vld", 32'(phase_vld), 32'h0);
        check("reset wrap_o",    32'(wrap_o),    32'h0);
        check("reset cfg_ready", 32'(cfg_ready), 32'h1);
        @(negedge clk_in);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit          rst_before;
        bit          e;
        bit          c;
        bit          v;
        bit          s;
        logic [31:0] d;
        logic [15:0] e_out;
        bit          e_vld;
        bit          e_wrap;
        bit          e_rdy;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // FTW=0x0100_0000: the apply edge still steps with the old FTW of 0,
        // so two zero samples precede 0x0100.
        vecs[0]  = '{1, 0, 0, 1, 0, 32'h0100_0000, 16'h0000, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 0, 32'h0,         16'h0000, 0, 0, 1};
        vecs[2]  = '{0, 1, 0, 0, 0, 32'h0,         16'h0000, 1, 0, 1};
        vecs[3]  = '{0, 1, 0, 0, 0, 32'h0,         16'h0000, 1, 0, 1};
        vecs[4]  = '{0, 1, 0, 0, 0, 32'h0,         16'h0100, 1, 0, 1};
        vecs[5]  = '{0, 1, 0, 0, 0, 32'h0,         16'h0200, 1, 0, 1};
        // FTW=0x4000_0000: quarter turns, wrap flag on the post-overflow zero.
        vecs[6]  = '{1, 0, 0, 1, 0, 32'h4000_0000, 16'h0000, 0, 0, 0};
        vecs[7]  = '{0, 1, 0, 0, 0, 32'h0,         16'h0000, 0, 0, 1};
        vecs[8]  = '{0, 1, 0, 0, 0, 32'h0,         16'h0000, 1, 0, 1};
        vecs[9]  = '{0, 1, 0, 0, 0, 32'h0,         16'h0000, 1, 0, 1};
        vecs[10] = '{0, 1, 0, 0, 0, 32'h0,         16'h4000, 1, 0, 1};
        vecs[11] = '{0, 1, 0, 0, 0, 32'h0,         16'h8000, 1, 0, 1};
        vecs[12] = '{0, 1, 0, 0, 0, 32'h0,         16'hC000, 1, 0, 1};
        vecs[13] = '{0, 1, 0, 0, 0, 32'h0,         16'h0000, 1, 1, 1};
        vecs[14] = '{0, 1, 0, 0, 0, 32'h0,         16'h4000, 1, 0, 1};

        model_reset();
        @(negedge clk_in);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].rst_before) do_reset();
            step(vecs[i].e, vecs[i].c, vecs[i].v, vecs[i].s, vecs[i].d);
            check($sformatf("vec%0d phase_out", i), 32'(phase_out), 32'(vecs[i].e_out));
            check($sformatf("vec%0d phase_vld", i), 32'(phase_vld), 32'(vecs[i].e_vld));
            check($sformatf("vec%0d wrap_o", i),    32'(wrap_o),    32'(vecs[i].e_wrap));
            check($sformatf("vec%0d cfg_ready", i), 32'(cfg_ready), 32'(vecs[i].e_rdy));
        end

        // POW write while running with FTW=0: ready low one cycle, phase
        // jumps two edges after the apply edge.
        do_reset();
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 1, 1, 32'h0000_8000);
        check("pow accept ready", 32'(cfg_ready), 32'h0);
        step(1, 0, 0, 0, 32'h0);
        check("pow apply ready", 32'(cfg_ready), 32'h1);
        step(1, 0, 0, 0, 32'h0);
        check("pow apply+1 phase", 32'(phase_out), 32'h0000);
        step(1, 0, 0, 0, 32'h0);
        check("pow apply+2 phase", 32'(phase_out), 32'h8000);

        // Pending config held while ena=0; a second offer is ignored.
        do_reset();
        step(0, 0, 1, 0, 32'h0100_0000);
        check("hold accept ready", 32'(cfg_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 32'h7777_0000);
            check("hold second offer ready", 32'(cfg_ready), 32'h0);
        end
        step(1, 0, 0, 0, 32'h0);
        check("hold apply ready", 32'(cfg_ready), 32'h1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h0);
        check("hold first ftw used", 32'(phase_out), 32'h0100);

        // phase_clr together with a pending FTW apply.
        do_reset();
        step(0, 0, 1, 0, 32'h1234_0000);
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 1, 0, 32'h0001_0000);
        step(1, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        check("clr seq a", 32'(phase_out), 32'h1234);
        check("clr seq a wrap", 32'(wrap_o), 32'h0);
        step(1, 0, 0, 0, 32'h0);
        check("clr seq zero", 32'(phase_out), 32'h0000);
        check("clr seq zero wrap", 32'(wrap_o), 32'h0);
        step(1, 0, 0, 0, 32'h0);
        check("clr seq newF", 32'(phase_out), 32'h0001);
        step(1, 0, 0, 0, 32'h0);
        check("clr seq 2newF", 32'(phase_out), 32'h0002);
        check("clr seq 2newF wrap", 32'(wrap_o), 32'h0);

        // Reset mid-stream with a config pending: it must be discarded.
        do_reset();
        step(0, 0, 1, 0, 32'h1000_0000);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 32'h0);
        step(0, 0, 1, 0, 32'h5555_0000);
        check("midrst pending ready", 32'(cfg_ready), 32'h0);
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 32'h0);
        check("midrst discarded cfg", 32'(phase_out), 32'h0000);
        check("midrst ready", 32'(cfg_ready), 32'h1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
